// File: rtl/proj_to_affine.sv
// proj_to_affine
// Converts a projective point (X:Y:Z) over GF(q) to affine form
// x_A = X/Z mod q, y_A = Y/Z mod q.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid / in_ready   input handshake; X_P, Y_P, Z_P, mod are captured on accept
//   out_valid / out_ready output handshake; x_A, y_A, inf_flag held until consumed
//   inf_flag              Z_P was zero, so the result is the point at infinity
//
// Flow: IDLE -> INV (2*DATA_WIDTH cycles, constant-time binary inverse of Z)
//       -> MULX -> MULY (DATA_WIDTH cycles each, bit-serial multiply) -> DONE.
//
// Optional macro P2A_DUAL_MUL_EN: two multipliers run in MULX together and
// MULY is skipped, cutting latency from 1+4*DATA_WIDTH to 1+3*DATA_WIDTH.
module proj_to_affine #(
  parameter int DATA_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] X_P,
  input  logic [DATA_WIDTH-1:0] Y_P,
  input  logic [DATA_WIDTH-1:0] Z_P,
  input  logic [DATA_WIDTH-1:0] mod,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] x_A,
  output logic [DATA_WIDTH-1:0] y_A,
  output logic                  inf_flag
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(2 * W);
  localparam logic [CW-1:0] INV_LAST = CW'(2 * W - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(W - 1);

  typedef enum logic [2:0] {IDLE, INV, MULX, MULY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  xr, yr;
  logic [W:0]    q_r;
  logic [W:0]    u, v, x1, x2;
  logic [W:0]    u_n, v_n, x1_n, x2_n;
  logic [W-1:0]  zinv_c;
  logic [W-1:0]  zsh;
  logic [W:0]    acc_x, acc_x_n;
`ifdef P2A_DUAL_MUL_EN
  logic [W:0]    acc_y, acc_y_n;
`endif

  // x/2 mod q; an odd x gets q added first so the shift is exact.
  function automatic logic [W:0] half_mod(input logic [W:0] x, input logic [W:0] q);
    logic [W:0] t;
    t = x[0] ? (x + q) : x;
    return t >> 1;
  endfunction

  // (a - b) mod q for a, b already in [0,q).
  function automatic logic [W:0] sub_mod(input logic [W:0] a, input logic [W:0] b,
                                         input logic [W:0] q);
    return (a >= b) ? (a - b) : (a + q - b);
  endfunction

  // One MSB-first interleaved multiply step: acc = 2*acc + bit*a, reduced after each add.
  function automatic logic [W:0] mul_step(input logic [W:0] acc, input logic [W-1:0] a,
                                          input logic b, input logic [W:0] q);
    logic [W:0] t;
    t = acc << 1;
    if (t >= q) t = t - q;
    if (b) t = t + {1'b0, a};
    if (t >= q) t = t - q;
    return t;
  endfunction

  // Binary extended-Euclid step. Invariants: x1*Z == u and x2*Z == v (mod q).
  // Subtract and halve are fused so each step shrinks log2(u*v) by at least
  // one bit, which bounds the loop at 2*W steps. Once u or v reaches 1 the
  // values freeze until the fixed cycle count runs out.
  always_comb begin
    u_n  = u;
    v_n  = v;
    x1_n = x1;
    x2_n = x2;
    if (u == 1 || v == 1) begin
      u_n = u;
    end else if (!u[0]) begin
      u_n  = u >> 1;
      x1_n = half_mod(x1, q_r);
    end else if (!v[0]) begin
      v_n  = v >> 1;
      x2_n = half_mod(x2, q_r);
    end else if (u >= v) begin
      u_n  = (u - v) >> 1;
      x1_n = half_mod(sub_mod(x1, x2, q_r), q_r);
    end else begin
      v_n  = (v - u) >> 1;
      x2_n = half_mod(sub_mod(x2, x1, q_r), q_r);
    end
    zinv_c = (u_n == 1) ? x1_n[W-1:0] : x2_n[W-1:0];
  end

  // Multiplier datapath; the shared unit picks X in MULX and Y in MULY.
  always_comb begin
`ifdef P2A_DUAL_MUL_EN
    acc_x_n = mul_step(acc_x, xr, zsh[W-1], q_r);
    acc_y_n = mul_step(acc_y, yr, zsh[W-1], q_r);
`else
    acc_x_n = mul_step(acc_x, (state == MULY) ? yr : xr, zsh[W-1], q_r);
`endif
  end

  // Control FSM and all registered state. zsh rotates rather than shifts so
  // that after MULX it holds Zinv again, ready for MULY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      xr        <= '0;
      yr        <= '0;
      q_r       <= '0;
      u         <= '0;
      v         <= '0;
      x1        <= '0;
      x2        <= '0;
      zsh       <= '0;
      acc_x     <= '0;
`ifdef P2A_DUAL_MUL_EN
      acc_y     <= '0;
`endif
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_A       <= '0;
      y_A       <= '0;
      inf_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr       <= X_P;
            yr       <= Y_P;
            q_r      <= {1'b0, mod};
            u        <= {1'b0, Z_P};
            v        <= {1'b0, mod};
            x1       <= (W + 1)'(1);
            x2       <= '0;
            cnt      <= '0;
            acc_x    <= '0;
`ifdef P2A_DUAL_MUL_EN
            acc_y    <= '0;
`endif
            x_A      <= '0;
            y_A      <= '0;
            in_ready <= 1'b0;
            if (Z_P == '0) begin
              inf_flag  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              inf_flag <= 1'b0;
              state    <= INV;
            end
          end
        end
        INV: begin
          u  <= u_n;
          v  <= v_n;
          x1 <= x1_n;
          x2 <= x2_n;
          if (cnt == INV_LAST) begin
            cnt   <= '0;
            zsh   <= zinv_c;
            state <= MULX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MULX: begin
          acc_x <= acc_x_n;
`ifdef P2A_DUAL_MUL_EN
          acc_y <= acc_y_n;
`endif
          zsh   <= {zsh[W-2:0], zsh[W-1]};
          if (cnt == MUL_LAST) begin
            cnt   <= '0;
            x_A   <= acc_x_n[W-1:0];
            acc_x <= '0;
`ifdef P2A_DUAL_MUL_EN
            y_A       <= acc_y_n[W-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
`else
            state <= MULY;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MULY: begin
          acc_x <= acc_x_n;
          zsh   <= {zsh[W-2:0], zsh[W-1]};
          if (cnt == MUL_LAST) begin
            cnt       <= '0;
            y_A       <= acc_x_n[W-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/proj_to_affine.md
PROJ_TO_AFFINE -- requirements
Module: proj_to_affine

Interface
REQ-001 Parameter DATA_WIDTH, default 30, sets the residue width in bits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  a projective point is offered on X_P/Y_P/Z_P/mod.
REQ-005 in_ready  output  1  block can accept a point.
REQ-006 X_P, Y_P, Z_P  input  DATA_WIDTH each  projective coordinates, ordinary residues mod q.
REQ-007 mod  input  DATA_WIDTH  odd prime modulus q, q < 2^DATA_WIDTH.
REQ-008 out_valid  output  1  affine result is presented.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 x_A, y_A  output  DATA_WIDTH each  affine coordinates X/Z, Y/Z mod q.
REQ-011 inf_flag  output  1  result is the point at infinity (Z_P == 0).

Function
REQ-012 States SHALL be IDLE, INV, MULX, MULY, DONE; the encoding is free.
REQ-013 IDLE: in_ready=1; in_valid=1 captures X_P, Y_P, Z_P and mod into registers; next state is INV, or DONE with inf_flag=1 and x_A=y_A=0 if Z_P==0.
REQ-014 in_ready SHALL be 1 only in IDLE; inputs are ignored in all other states.
REQ-015 INV: binary extended-Euclid inverse of Z mod q, one step per cycle.
  - Fixed 2*DATA_WIDTH cycles (constant time).
  - Once u==1 or v==1 the result is held until the count expires.
REQ-016 INV intermediates SHALL be DATA_WIDTH+1 bits so that x+q cannot overflow; every value written back SHALL be reduced to [0,q).
REQ-017 MULX: bit-serial interleaved modular multiply x_A = X*Zinv mod q.
  - MSB first, DATA_WIDTH cycles.
  - Per step: acc = 2*acc (-q if >= q), + b_i*X (-q if >= q).
REQ-018 MULY: same operation for y_A = Y*Zinv mod q, DATA_WIDTH cycles; then go to DONE.
REQ-019 DONE: out_valid=1 with x_A, y_A, inf_flag stable; out_ready=1 returns to IDLE in the next cycle.
REQ-020 out_valid without out_ready SHALL hold all outputs unchanged indefinitely.
REQ-021 Latency from the accept edge to out_valid:
  - Sequential multiplies: 1+2*DATA_WIDTH+2*DATA_WIDTH cycles (121 at default).
  - Infinity path: exactly 1 cycle.
REQ-022 No new point SHALL be accepted in the cycle a result is consumed (no back-to-back accept in DONE).
REQ-023 Outputs SHALL satisfy x_A,y_A < q for all inputs < q; inputs >= q or an even q give unspecified results without hang.

Reset
REQ-024 rst SHALL force state IDLE, in_ready=1, out_valid=0, x_A=y_A=0, inf_flag=0, and clear all counters.
REQ-025 rst asserted mid-operation SHALL abort the computation; no out_valid follows until a new accept.

Configuration
REQ-026 Macro P2A_DUAL_MUL_EN: when defined, two multipliers compute x_A and y_A concurrently in MULX, MULY is skipped, and latency is 1+3*DATA_WIDTH (91 at default).
REQ-027 Without P2A_DUAL_MUL_EN: one shared multiplier, MULX then MULY, with latency per REQ-021.
REQ-028 Outputs SHALL be bit-identical with and without the macro.

Verification
REQ-029 q=13, X=6, Y=10, Z=2 -> x_A=3, y_A=5, inf_flag=0, out_valid exactly 121 (or 91) cycles after accept.
REQ-030 q=13, X=1, Y=12, Z=3 -> x_A=9, y_A=4 (Zinv=9).
REQ-031 q=1000000007, Z=1, X=123456789, Y=999999999 -> x_A=X, y_A=Y.
REQ-032 Z_P=0, any X/Y -> out_valid 1 cycle after accept, inf_flag=1, x_A=y_A=0.
REQ-033 Hold out_ready=0 for 50 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle, and a new point is accepted.
REQ-034 Assert rst at cycle 40 of INV -> out_valid=0, in_ready=1 immediately; rerun REQ-029 -> correct result.
